resync_fifo: RTL and testbench



---
 rtl/resync_fifo_pkg.sv | 20 ++
 rtl/resync_fifo_mem.sv | 33 +++
 rtl/resync_fifo.sv | 89 ++++++++
 tb/tb_resync_fifo.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/resync_fifo_pkg.sv
// Shared defaults and the per-cycle operation decode for the resync FIFO.
package resync_fifo_pkg;

   localparam int unsigned DEF_WIDTH     = 20;
   localparam int unsigned DEF_LOG_DEPTH = 3;

   // Accepted operation this cycle; the encoding is {pop, push}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_t;

   // Combine accepted push/pop strobes into one operation code.
   function automatic fifo_op_t decode_op(input logic push, input logic pop);
      return fifo_op_t'({pop, push});
   endfunction

endpackage

// File: rtl/resync_fifo_mem.sv
// Storage array for resync_fifo: synchronous write, asynchronous read, cleared on reset.
module resync_fifo_mem #(
   parameter int unsigned width     = 20,
   parameter int unsigned log_depth = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wen,
   input  logic [log_depth-1:0] waddr,
   input  logic [width-1:0]     wdata,
   input  logic [log_depth-1:0] raddr,
   output logic [width-1:0]     rdata
);

   localparam int unsigned depth = 2 ** log_depth;

   logic [width-1:0] mem [depth];

   // Write port; every entry is zeroed so stale reads after reset return 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < depth; i++) begin
            mem[i] <= '0;
         end
      end else if (wen) begin
         mem[waddr] <= wdata;
      end
   end

   // Show-ahead read port.
   assign rdata = mem[raddr];

endmodule

// File: rtl/resync_fifo.sv
// Show-ahead single-clock elastic FIFO between deserializer word assembly and parallel output.
module resync_fifo
   import resync_fifo_pkg::*;
#(
   parameter int unsigned width     = DEF_WIDTH,
   parameter int unsigned log_depth = DEF_LOG_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             val_wr,
   input  logic [width-1:0] data_wr,
   input  logic             val_rd,
   output logic [width-1:0] data_rd,
   output logic             empty_rd,
   output logic             full_wr,
   output logic             almost_empty_rd
);

   localparam int unsigned depth = 2 ** log_depth;
   localparam int unsigned ptr_w = log_depth;
   localparam int unsigned cnt_w = log_depth + 1;
   localparam logic [cnt_w-1:0] depth_cnt = cnt_w'(depth);

   logic [ptr_w-1:0] wr_ptr;
   logic [ptr_w-1:0] rd_ptr;
   logic [cnt_w-1:0] count;
   logic             push_ok;
   logic             pop_ok;
   fifo_op_t         op;

   // Accept only when the FIFO can honour the request; the rest is dropped silently.
   always_comb begin
      push_ok = val_wr & ~full_wr;
      pop_ok  = val_rd & ~empty_rd;
      op      = decode_op(push_ok, pop_ok);
   end

   // Occupancy decodes.
   always_comb begin
      empty_rd        = (count == '0);
      almost_empty_rd = (count == cnt_w'(1));
      full_wr         = (count == depth_cnt);
   end

   // Write pointer, wraps modulo depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (push_ok) begin
         wr_ptr <= wr_ptr + ptr_w'(1);
      end
   end

   // Read pointer, wraps modulo depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
      end else if (pop_ok) begin
         rd_ptr <= rd_ptr + ptr_w'(1);
      end
   end

   // Occupancy counter; push and pop together leave it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case (op)
            OP_PUSH: count <= count + cnt_w'(1);
            OP_POP:  count <= count - cnt_w'(1);
            default: count <= count;
         endcase
      end
   end

   resync_fifo_mem #(
      .width     (width),
      .log_depth (log_depth)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .wen   (push_ok),
      .waddr (wr_ptr),
      .wdata (data_wr),
      .raddr (rd_ptr),
      .rdata (data_rd)
   );

endmodule

// File: tb/tb_resync_fifo.sv
// Directed self-checking bench for resync_fifo (width 20, depth 8).
module tb_resync_fifo;

   logic        clk;
   logic        rst_n;
   logic        val_wr;
   logic [19:0] data_wr;
   logic        val_rd;
   logic [19:0] data_rd;
   logic        empty_rd;
   logic        full_wr;
   logic        almost_empty_rd;

   int unsigned checks;
   int unsigned errors;
   logic [19:0] q [$];
   int unsigned pops;

   resync_fifo #(.width(20), .log_depth(3)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .val_wr          (val_wr),
      .data_wr         (data_wr),
      .val_rd          (val_rd),
      .data_rd         (data_rd),
      .empty_rd        (empty_rd),
      .full_wr         (full_wr),
      .almost_empty_rd (almost_empty_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report a mismatch.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; return 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      val_wr = 1'b0;
      val_rd = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic e, input logic ae, input logic f);
      check({tag, "_empty"}, 32'(empty_rd), 32'(e));
      check({tag, "_aempty"}, 32'(almost_empty_rd), 32'(ae));
      check({tag, "_full"}, 32'(full_wr), 32'(f));
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      val_wr  = 1'b0;
      val_rd  = 1'b0;
      data_wr = '0;
      repeat (3) step();
      check_flags("rst", 1'b1, 1'b0, 1'b0);
      check("rst_data", 32'(data_rd), 32'h0);
      rst_n = 1'b1;
      step();

      // Single word in, then out.
      val_wr = 1'b1; data_wr = 20'h5A5A5;
      step();
      idle();
      check("single_data", 32'(data_rd), 32'h5A5A5);
      check_flags("single", 1'b0, 1'b1, 1'b0);
      val_rd = 1'b1;
      step();
      idle();
      check_flags("single_pop", 1'b1, 1'b0, 1'b0);
      check("stale_zero", 32'(data_rd), 32'h0);

      // Pop while empty is ignored.
      val_rd = 1'b1;
      step();
      idle();
      check_flags("pop_empty", 1'b1, 1'b0, 1'b0);
      check("pop_empty_data", 32'(data_rd), 32'h0);

      // Fill with 1..8, then try a dropped 9th push.
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("fill_full_before_%0d", i), 32'(full_wr), 32'h0);
         val_wr = 1'b1; data_wr = 20'(i);
         step();
      end
      idle();
      check_flags("filled", 1'b0, 1'b0, 1'b1);
      check("filled_head", 32'(data_rd), 32'h1);
      val_wr = 1'b1; data_wr = 20'hFF;
      step();
      idle();
      check_flags("drop9", 1'b0, 1'b0, 1'b1);
      check("drop9_head", 32'(data_rd), 32'h1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain_%0d", i), 32'(data_rd), 32'(i));
         val_rd = 1'b1;
         step();
      end
      idle();
      check_flags("drained", 1'b1, 1'b0, 1'b0);

      // Push+pop while full: only the pop takes effect.
      for (int i = 0; i < 8; i++) begin
         val_wr = 1'b1; data_wr = 20'(32'h10 + 32'(i));
         step();
      end
      idle();
      check("refill_full", 32'(full_wr), 32'h1);
      val_wr = 1'b1; val_rd = 1'b1; data_wr = 20'hAB;
      step();
      idle();
      check_flags("both_full", 1'b0, 1'b0, 1'b0);
      check("both_full_head", 32'(data_rd), 32'h11);
      for (int i = 1; i < 8; i++) begin
         check($sformatf("drain7_%0d", i), 32'(data_rd), 32'(32'h10 + 32'(i)));
         val_rd = 1'b1;
         step();
      end
      idle();
      check_flags("drain7_end", 1'b1, 1'b0, 1'b0);

      // Push+pop while empty: only the push takes effect.
      val_wr = 1'b1; val_rd = 1'b1; data_wr = 20'h123;
      step();
      idle();
      check_flags("both_empty", 1'b0, 1'b1, 1'b0);
      check("both_empty_head", 32'(data_rd), 32'h123);

      // Build up to three words, then stream push+pop for 20 cycles.
      q = {};
      q.push_back(20'h123);
      for (int i = 0; i < 2; i++) begin
         val_wr = 1'b1; data_wr = 20'(32'h124 + 32'(i));
         q.push_back(data_wr);
         step();
      end
      idle();
      for (int i = 0; i < 20; i++) begin
         check($sformatf("stream_out_%0d", i), 32'(data_rd), 32'(q[0]));
         void'(q.pop_front());
         val_wr = 1'b1; val_rd = 1'b1; data_wr = 20'(32'h126 + 32'(i));
         q.push_back(data_wr);
         step();
         check_flags($sformatf("stream_%0d", i), 1'b0, 1'b0, 1'b0);
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stream_tail_%0d", i), 32'(data_rd), 32'(q[0]));
         void'(q.pop_front());
         val_rd = 1'b1;
         step();
      end
      idle();
      check_flags("stream_end", 1'b1, 1'b0, 1'b0);

      // Slack-keeping consumer against a slow producer.
      q = {};
      pops = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         val_wr  = (cyc % 20 == 0);
         data_wr = 20'(32'h300 + 32'(cyc));
         val_rd  = !empty_rd && !almost_empty_rd;
         if (val_rd) begin
            check($sformatf("slack_out_%0d", cyc), 32'(data_rd), 32'(q[0]));
            void'(q.pop_front());
            pops++;
         end
         if (val_wr) q.push_back(data_wr);
         check($sformatf("slack_full_%0d", cyc), 32'(full_wr), 32'h0);
         step();
      end
      idle();
      check("slack_pops", 32'(pops), 32'd9);
      check_flags("slack_end", 1'b0, 1'b1, 1'b0);
      check("slack_last", 32'(data_rd), 32'h300 + 32'd180);

      // Asynchronous reset mid-stream discards contents.
      for (int i = 0; i < 3; i++) begin
         val_wr = 1'b1; data_wr = 20'(32'hABC00 + 32'(i));
         step();
      end
      idle();
      check("prereset_head", 32'(data_rd), 32'h300 + 32'd180);
      #2;
      rst_n = 1'b0;
      #1;
      check_flags("async_rst", 1'b1, 1'b0, 1'b0);
      check("async_rst_data", 32'(data_rd), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      check_flags("post_rst", 1'b1, 1'b0, 1'b0);
      check("post_rst_data", 32'(data_rd), 32'h0);
      val_wr = 1'b1; data_wr = 20'h77777;
      step();
      idle();
      check("post_rst_push", 32'(data_rd), 32'h77777);
      check_flags("post_rst_push", 1'b0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
